// File: rtl/matrix_scroll_ctrl.sv
// rtl/matrix_scroll_ctrl.sv - scrolling LED matrix scan/scroll controller (optional blink via MATRIX_BLINK_EN)
module matrix_scroll_ctrl #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DEPTH      = 16,
    parameter int SCROLL_DIV = 12500000,
    parameter int SCAN_DIV   = 8192,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int SW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            dir,
`ifdef MATRIX_BLINK_EN
    input  logic            blink,
`endif
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [COLS-1:0] wr_data,
    output logic [COLS-1:0] segout,
    output logic [SW-1:0]   scanout,
    output logic            frame_tick
);

    localparam int SCANW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SCROLLW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    // One extra bit so offset + scanout never overflows before the modulo fold.
    localparam int IW      = AW + 1;

    localparam logic [SCANW-1:0]   SCAN_LAST   = SCANW'(SCAN_DIV - 1);
    localparam logic [SCROLLW-1:0] SCROLL_LAST = SCROLLW'(SCROLL_DIV - 1);
    localparam logic [SW-1:0]      ROW_LAST    = SW'(ROWS - 1);
    localparam logic [AW-1:0]      OFF_LAST    = AW'(DEPTH - 1);

    logic [SCANW-1:0]   scan_cnt;
    logic [SCROLLW-1:0] scroll_cnt;
    logic [AW-1:0]      offset;
    logic [COLS-1:0]    mem [DEPTH];
    logic               scan_term;
    logic               scroll_run;
    logic               scroll_term;
    logic [IW-1:0]      row_sum;
    logic [AW-1:0]      row_idx;
    logic               force_dark;

`ifdef MATRIX_BLINK_EN
    logic phase;
    assign scroll_run = en | blink;
    assign force_dark = blink & phase;
`else
    assign scroll_run = en;
    assign force_dark = 1'b0;
`endif

    assign scan_term   = (scan_cnt == SCAN_LAST);
    assign scroll_term = scroll_run && (scroll_cnt == SCROLL_LAST);

    // Fold offset + scanout back into 0..DEPTH-1; both terms are below DEPTH so one subtract suffices.
    always_comb begin
        row_sum = IW'(offset) + IW'(scanout);
        row_idx = AW'(row_sum);
        if (row_sum >= IW'(DEPTH)) begin
            row_idx = AW'(row_sum - IW'(DEPTH));
        end
    end

    // Scan-line divider, active line index and frame pulse on wrap to line 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt   <= '0;
            scanout    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (scan_term) begin
                scan_cnt <= '0;
                if (scanout == ROW_LAST) begin
                    scanout    <= '0;
                    frame_tick <= 1'b1;
                end else begin
                    scanout <= scanout + 1'b1;
                end
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // Scroll divider; offset moves only when scrolling is enabled, with exact wrap for any DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scroll_cnt <= '0;
            offset     <= '0;
        end else if (scroll_run) begin
            if (scroll_term) begin
                scroll_cnt <= '0;
                if (en) begin
                    if (dir) begin
                        offset <= (offset == '0) ? OFF_LAST : offset - 1'b1;
                    end else begin
                        offset <= (offset == OFF_LAST) ? '0 : offset + 1'b1;
                    end
                end
            end else begin
                scroll_cnt <= scroll_cnt + 1'b1;
            end
        end
    end

`ifdef MATRIX_BLINK_EN
    // Blink phase flips on every scroll-counter terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= 1'b0;
        end else if (scroll_term) begin
            phase <= ~phase;
        end
    end
`endif

    // Pattern memory; reset blanks every row so the display comes up dark.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '1;
            end
        end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered column drive for the currently addressed pattern row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            segout <= '1;
        end else if (force_dark) begin
            segout <= '1;
        end else begin
            segout <= mem[row_idx];
        end
    end

endmodule

// File: tb/tb_matrix_scroll_ctrl.sv
// tb/tb_matrix_scroll_ctrl.sv - randomized self-checking bench for matrix_scroll_ctrl
module tb_matrix_scroll_ctrl;

    localparam int ROWS       = 4;
    localparam int COLS       = 8;
    localparam int DEPTH      = 6;
    localparam int SCROLL_DIV = 4;
    localparam int SCAN_DIV   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] segout;
    logic [1:0] scanout;
    logic       frame_tick;
`ifdef MATRIX_BLINK_EN
    logic       blink = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: elapsed edges since reset, enabled edges, offset, memory image.
    int         m_k;
    int         m_run_cnt;
    int         m_off;
    int         m_phase;
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_seg;

    matrix_scroll_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH),
        .SCROLL_DIV(SCROLL_DIV), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .dir(dir),
`ifdef MATRIX_BLINK_EN
        .blink(blink),
`endif
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .segout(segout),
        .scanout(scanout),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic int m_scan();
        return (m_k / SCAN_DIV) % ROWS;
    endfunction

    function automatic logic m_frame();
        return (m_k > 0) && ((m_k % (SCAN_DIV * ROWS)) == 0);
    endfunction

    task automatic model_reset();
        m_k       = 0;
        m_run_cnt = 0;
        m_off     = 0;
        m_phase   = 0;
        m_seg     = 8'hFF;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hFF;
    endtask

    task automatic model_edge();
        logic run;
        logic dark;
        run  = en;
        dark = 1'b0;
`ifdef MATRIX_BLINK_EN
        run  = en | blink;
        dark = blink && (m_phase == 1);
`endif
        m_seg = dark ? 8'hFF : m_mem[(m_off + m_scan()) % DEPTH];
        if (wr_en) m_mem[wr_addr] = wr_data;
        m_k++;
        if (run) begin
            m_run_cnt++;
            if ((m_run_cnt % SCROLL_DIV) == 0) begin
                m_phase = 1 - m_phase;
                if (en) m_off = dir ? (m_off + DEPTH - 1) % DEPTH : (m_off + 1) % DEPTH;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b0;
        en    = 1'b0;
        wr_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_pattern();
        en = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(k);
            wr_data = 8'h10 + 8'(k);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (segout !== 8'hFF) begin n_fail++; $display("FAIL reset_segout got %h want ff", segout); end
        n_checks++;
        if (scanout !== 2'd0) begin n_fail++; $display("FAIL reset_scanout got %0d want 0", scanout); end
        n_checks++;
        if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame got %b want 0", frame_tick); end
        en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 17; c++) begin
            tick();
            n_checks++;
            if (scanout !== 2'(m_scan())) begin
                n_fail++; $display("FAIL scan_seq cyc %0d got %0d want %0d", c, scanout, m_scan());
            end
            n_checks++;
            if (frame_tick !== m_frame()) begin
                n_fail++; $display("FAIL frame_seq cyc %0d got %b want %b", c, frame_tick, m_frame());
            end
        end
    endtask

    task automatic test_reset_mid_write();
        load_pattern();
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'h00;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (segout !== 8'hFF) begin
                n_fail++; $display("FAIL no_partial_write cyc %0d got %h want ff", c, segout);
            end
        end
    endtask

    task automatic test_scroll_up();
        apply_reset();
        load_pattern();
        en  = 1'b1;
        dir = 1'b0;
        for (int c = 0; c < SCROLL_DIV * 8; c++) begin
            tick();
            n_checks++;
            if (segout !== m_seg || scanout !== 2'(m_scan())) begin
                n_fail++; $display("FAIL scroll_up cyc %0d got %h/%0d want %h/%0d", c, segout, scanout, m_seg, m_scan());
            end
        end
        en = 1'b0;
    endtask

    task automatic test_scroll_down();
        int ps;
        apply_reset();
        load_pattern();
        en  = 1'b1;
        dir = 1'b1;
        repeat (SCROLL_DIV) tick();
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ps = m_scan();
            tick();
            if (ps == 0) begin
                n_checks++;
                if (segout !== 8'h15) begin n_fail++; $display("FAIL down_line0 got %h want 15", segout); end
            end
            if (ps == 3) begin
                n_checks++;
                if (segout !== 8'h12) begin n_fail++; $display("FAIL down_line3 got %h want 12", segout); end
            end
        end
    endtask

    task automatic test_pause();
        en  = 1'b1;
        dir = 1'b0;
        repeat (2) tick();
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (segout !== m_seg) begin
                n_fail++; $display("FAIL pause_hold cyc %0d got %h want %h", c, segout, m_seg);
            end
        end
        en = 1'b1;
        for (int c = 0; c < 3 * SCROLL_DIV; c++) begin
            tick();
            n_checks++;
            if (segout !== m_seg) begin
                n_fail++; $display("FAIL pause_resume cyc %0d got %h want %h", c, segout, m_seg);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_write_displayed();
        int next_idx;
        next_idx = (((m_k + 1) / SCAN_DIV) % ROWS + m_off) % DEPTH;
        wr_en    = 1'b1;
        wr_addr  = 3'(next_idx);
        wr_data  = 8'hA5;
        tick();
        wr_en = 1'b0;
        tick();
        n_checks++;
        if (segout !== 8'hA5) begin n_fail++; $display("FAIL write_visible got %h want a5", segout); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            en      = ($urandom_range(0, 3) != 0);
            dir     = 1'($urandom_range(0, 1));
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, DEPTH - 1));
            wr_data = 8'($urandom);
            tick();
            n_checks++;
            if (segout !== m_seg || scanout !== 2'(m_scan()) || frame_tick !== m_frame()) begin
                n_fail++;
                $display("FAIL random cyc %0d got %h/%0d/%b want %h/%0d/%b",
                         c, segout, scanout, frame_tick, m_seg, m_scan(), m_frame());
            end
        end
        wr_en = 1'b0;
        en    = 1'b0;
    endtask

`ifdef MATRIX_BLINK_EN
    task automatic test_blink();
        apply_reset();
        load_pattern();
        blink = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            n_checks++;
            if (segout !== m_seg) begin
                n_fail++; $display("FAIL blink cyc %0d got %h want %h", c, segout, m_seg);
            end
        end
        blink = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (segout !== m_mem[(m_off + ((m_k - 1) / SCAN_DIV) % ROWS) % DEPTH]) begin
                n_fail++; $display("FAIL blink_off cyc %0d got %h want %h", c, segout, m_seg);
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_reset_mid_write();
        test_scroll_up();
        test_scroll_down();
        test_pause();
        test_write_displayed();
        test_random();
`ifdef MATRIX_BLINK_EN
        test_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
